// File: rtl/clock_signal_monitor_pkg.sv
// Shared types and constants for clock_signal_monitor: FSM state encoding, default
// parameter values and a legality check for the timeout/counter-width pair.
package clock_signal_monitor_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StLocked,
        StLost
    } state_e;

    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefCntW       = 16;
    localparam int unsigned DefTimeout    = 1000;

    // The counter saturates at the timeout, so the timeout must fit in cnt_w bits.
    function automatic logic timeout_legal(int unsigned timeout, int unsigned cnt_w);
        logic fits;
        if (cnt_w >= 32) begin
            fits = 1'b1;
        end else begin
            fits = (timeout <= ((32'd1 << cnt_w) - 32'd1));
        end
        return (timeout >= 2) && (cnt_w >= 1) && fits;
    endfunction

endpackage

// File: rtl/clock_signal_monitor_sync.sv
// Synchronizer chain for a foreign clock sampled as data, plus level/rise-strobe outputs.
// Define CLOCK_SIGNAL_MONITOR_GLITCH_FILTER_EN to add a 2-sample agreement filter.
module clock_signal_monitor_sync
    import clock_signal_monitor_pkg::*;
#(
    parameter int unsigned SyncStages = DefSyncStages
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic data_i,
    output logic level_o,
    output logic rise_event_o,
    output logic rise_o
);

    logic [SyncStages-1:0] sync_q, sync_d;
    logic                  level;
    logic                  level_prev_q, level_prev_d;
    logic                  rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[SyncStages-2:0], data_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef CLOCK_SIGNAL_MONITOR_GLITCH_FILTER_EN
    logic filt_q, filt_d;

    // Follow the synchronized input only when the last two stages agree.
    always_comb begin
        filt_d = filt_q;
        if (sync_q[SyncStages-1] == sync_q[SyncStages-2]) begin
            filt_d = sync_q[SyncStages-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[SyncStages-1];
`endif

    always_comb begin
        level_prev_d = level;
        rise_d       = level & ~level_prev_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_prev_q <= 1'b0;
            rise_q       <= 1'b0;
        end else begin
            level_prev_q <= level_prev_d;
            rise_q       <= rise_d;
        end
    end

    assign level_o      = level;
    assign rise_event_o = rise_d;
    assign rise_o       = rise_q;

endmodule

// File: rtl/clock_signal_monitor.sv
// Observes a foreign clock as data: synchronized level, rise strobe, period measurement
// and loss-of-clock detection. Optional filter: CLOCK_SIGNAL_MONITOR_GLITCH_FILTER_EN.
module clock_signal_monitor
    import clock_signal_monitor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned TIMEOUT     = DefTimeout
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clock_in,
    output logic             signal_out,
    output logic             rise,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("clock_signal_monitor: SYNC_STAGES must be at least 2");
    end
    if (!timeout_legal(TIMEOUT, CNT_W)) begin : g_bad_timeout
        $error("clock_signal_monitor: TIMEOUT must be in [2, 2**CNT_W-1]");
    end

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    logic             rise_event;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;
    logic             timeout_hit;

    clock_signal_monitor_sync #(
        .SyncStages(SYNC_STAGES)
    ) u_sync (
        .clk_i       (clock),
        .rst_i       (reset),
        .data_i      (clock_in),
        .level_o     (signal_out),
        .rise_event_o(rise_event),
        .rise_o      (rise)
    );

    // Saturating counter: a rise restarts it at 1 so that cnt equals the period on the next rise.
    always_comb begin
        cnt_d = cnt_q;
        if (rise_event) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != TimeoutCnt) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (cnt_q == TimeoutCnt);

    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        lost_d         = lost_q;
        unique case (state_q)
            StIdle: begin
                if (rise_event) begin
                    state_d = StMeasure;
                end else if (timeout_hit) begin
                    state_d  = StLost;
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                end
            end
            StMeasure, StLocked: begin
                if (rise_event) begin
                    state_d        = StLocked;
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    locked_d       = 1'b1;
                end else if (timeout_hit) begin
                    state_d  = StLost;
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                end
            end
            StLost: begin
                if (rise_event) begin
                    state_d = StMeasure;
                    lost_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            lost_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            lost_q         <= lost_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign lost         = lost_q;

endmodule

// File: tb/tb_clock_signal_monitor.sv
// Self-checking bench for clock_signal_monitor: expected periods are queued as edges are
// driven and popped on each period_valid pulse.
module tb_clock_signal_monitor;

    localparam int unsigned CntW    = 16;
    localparam int unsigned Timeout = 1000;
`ifdef CLOCK_SIGNAL_MONITOR_GLITCH_FILTER_EN
    localparam int Lat = 3;
`else
    localparam int Lat = 2;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            clock_in = 1'b0;
    logic            signal_out;
    logic            rise;
    logic [CntW-1:0] period;
    logic            period_valid;
    logic            locked;
    logic            lost;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rise_cyc = 0;
    int sb[$];

    clock_signal_monitor #(
        .SYNC_STAGES(2),
        .CNT_W      (CntW),
        .TIMEOUT    (Timeout)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clock_in    (clock_in),
        .signal_out  (signal_out),
        .rise        (rise),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .lost        (lost)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Each edge is driven at a negedge and sampled at the next posedge (cyc + 1).
    task automatic drive_edges(input int p, input int n, input bit first_counts);
        for (int i = 0; i < n; i++) begin
            clock_in = 1'b1;
            if (i > 0 || first_counts) sb.push_back(cyc + 1 - last_rise_cyc);
            last_rise_cyc = cyc + 1;
            repeat (p / 2) @(negedge clock);
            clock_in = 1'b0;
            repeat (p - p / 2) @(negedge clock);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_signal_out"}, signal_out, 0);
        check_val({tag, "_rise"}, rise, 0);
        check_val({tag, "_period"}, period, 0);
        check_val({tag, "_period_valid"}, period_valid, 0);
        check_val({tag, "_locked"}, locked, 0);
        check_val({tag, "_lost"}, lost, 0);
    endtask

    always @(negedge clock) begin
        if (!reset && period_valid) begin
            if (sb.size() == 0) begin
                check_val("pv_spurious", period_valid, 0);
            end else begin
                automatic int exp = sb.pop_front();
                check_val("period", period, exp);
                check_val("locked_at_pv", locked, 1);
            end
        end
    end

    initial begin
        int k;
        int n_rise;
        int sig_max;

        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Steady period 8, then a change to 13.
        drive_edges(8, 6, 1'b0);
        check_val("locked_p8", locked, 1);
        drive_edges(13, 4, 1'b1);
        check_val("locked_p13", locked, 1);

        // Stuck low: lost exactly Lat + TIMEOUT cycles after the last sampled rise.
        k = last_rise_cyc;
        while (!lost && cyc < k + Lat + Timeout + 100) @(negedge clock);
        check_val("lost_latency", cyc - k, Lat + Timeout);
        check_val("lost_locked", locked, 0);
        check_val("lost_period_hold", period, 13);

        // Restart: first rise clears lost, second relocks.
        drive_edges(8, 1, 1'b0);
        check_val("relock1_lost", lost, 0);
        check_val("relock1_locked", locked, 0);
        drive_edges(8, 2, 1'b1);
        check_val("relock2_locked", locked, 1);

        // Rises landing exactly on cnt == TIMEOUT must not declare loss.
        drive_edges(1000, 2, 1'b1);
        drive_edges(8, 1, 1'b1);
        check_val("boundary_lost", lost, 0);
        check_val("boundary_locked", locked, 1);

        // Reset mid-period.
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("midreset");
        reset = 1'b0;
        @(negedge clock);
        check_val("postreset_pv", period_valid, 0);
        check_val("postreset_rise", rise, 0);
        drive_edges(8, 1, 1'b0);
        check_val("postreset1_period", period, 0);
        check_val("postreset1_locked", locked, 0);
        drive_edges(8, 2, 1'b1);
        check_val("postreset2_locked", locked, 1);

        // Single-cycle glitch from a fresh reset.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        clock_in = 1'b1;
        @(negedge clock);
        clock_in = 1'b0;
        n_rise  = 0;
        sig_max = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (rise) n_rise++;
            if (signal_out) sig_max = 1;
        end
`ifdef CLOCK_SIGNAL_MONITOR_GLITCH_FILTER_EN
        check_val("glitch_rise_count", n_rise, 0);
        check_val("glitch_signal_out", sig_max, 0);
`else
        check_val("glitch_rise_count", n_rise, 1);
        check_val("glitch_signal_out", sig_max, 1);
`endif

        check_val("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
